// File: rtl/vga_fb_arbiter.sv
// Arbitrates a single-port framebuffer RAM between VGA scan-out reads and
// FIFO-buffered host pixel writes, which drain only during blanking.
module vga_fb_arbiter #(
  parameter int HVID       = 640,
  parameter int VVID       = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_25,
  input  logic                          rst_n,
  input  logic [9:0]                    pixel_x,
  input  logic [9:0]                    pixel_y,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          pix_valid,
  output logic [DATA_W-1:0]             pix_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [9:0]       HVID_C  = 10'(HVID);
  localparam logic [9:0]       VVID_C  = 10'(VVID);
  localparam logic [LVL_W-1:0] DEPTH_C = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {BLANK_IDLE, BLANK_WRITE, SCAN} state_t;

  state_t state_reg, state_next;

  logic                     run_reg;
  logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]         level_reg;
  logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [ADDR_W-1:0] addr_hold_reg, rd_addr, head_addr;
  logic [DATA_W-1:0] wdata_hold_reg, head_data;

  logic active, fifo_empty, push, pop, do_read;
  logic active_d_reg, pix_valid_reg;
  logic [DATA_W-1:0] pix_data_reg;

  assign active     = (pixel_x < HVID_C) && (pixel_y < VVID_C);
  assign fifo_empty = (level_reg == '0);
  // Linear address computed modulo 2^ADDR_W, so wrap/truncation is implicit.
  assign rd_addr    = ADDR_W'(pixel_y) * ADDR_W'(HVID) + ADDR_W'(pixel_x);
  assign {head_addr, head_data} = fifo_mem[rd_ptr_reg];

  // run_reg stays low through reset and one clock beyond, blocking all RAM traffic.
  always_comb begin
    state_next = state_reg;
    if (!run_reg) begin
      state_next = BLANK_IDLE;
    end else begin
      case (state_reg)
        SCAN:        if (!active) state_next = fifo_empty ? BLANK_IDLE : BLANK_WRITE;
        BLANK_IDLE:  if (active) state_next = SCAN;
                     else if (!fifo_empty) state_next = BLANK_WRITE;
        BLANK_WRITE: if (active) state_next = SCAN;
                     else if (fifo_empty) state_next = BLANK_IDLE;
        default:     state_next = BLANK_IDLE;
      endcase
    end
  end

  // The RAM operation follows the state being entered this cycle, so an
  // interrupted drain yields to the display read with no lost cycle.
  assign do_read   = (state_next == SCAN);
  assign pop       = (state_next == BLANK_WRITE);
  assign wr_ready  = run_reg && (level_reg < DEPTH_C);
  assign push      = wr_valid && wr_ready;

  assign mem_en    = do_read || pop;
  assign mem_we    = pop;
  assign mem_addr  = do_read ? rd_addr : (pop ? head_addr : addr_hold_reg);
  assign mem_wdata = pop ? head_data : wdata_hold_reg;

  assign fifo_level = level_reg;
  assign pix_valid  = pix_valid_reg;
  assign pix_data   = pix_data_reg;

  always_ff @(posedge clk_25) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= BLANK_IDLE;
      run_reg        <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
      active_d_reg   <= 1'b0;
      pix_valid_reg  <= 1'b0;
      pix_data_reg   <= '0;
    end else begin
      state_reg <= state_next;
      run_reg   <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (mem_en) addr_hold_reg <= mem_addr;
      if (pop)    wdata_hold_reg <= head_data;
      // Two-stage pixel pipe: RAM read latency plus the output register.
      active_d_reg  <= do_read;
      pix_valid_reg <= active_d_reg;
      pix_data_reg  <= active_d_reg ? mem_rdata : '0;
    end
  end

endmodule
